// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor: diff = a - b (mod 2^WIDTH), processed LSB
// first through a single 1-bit full-subtractor cell with a registered borrow.
// A start pulse in IDLE captures both operands. The result is delivered in
// parallel together with a one-cycle done pulse.
//
// Ports:
//   clk        in   1      clock, all state changes on the rising edge
//   rst        in   1      synchronous active-high reset
//   start      in   1      operation request, honoured only in IDLE
//   a          in   WIDTH  minuend, captured on the accepting edge
//   b          in   WIDTH  subtrahend, captured on the accepting edge
//   busy       out  1      high while an operation is in RUN or DONE
//   done       out  1      one-cycle pulse, diff/borrow_out valid from here
//   diff       out  WIDTH  (a - b) mod 2^WIDTH, held until next completion
//   borrow_out out  1      final borrow, i.e. a < b
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Full-subtractor difference bit: x - y - bin.
    function automatic logic fs_diff(input logic x, input logic y, input logic bin);
        return x ^ y ^ bin;
    endfunction

    // Full-subtractor borrow: borrow when y exceeds x, or when x == y and a
    // borrow is already pending.
    function automatic logic fs_borrow(input logic x, input logic y, input logic bin);
        return (~x & y) | (~(x ^ y) & bin);
    endfunction

    state_t           state_r, state_s;
    logic [WIDTH-1:0] sa_r, sa_s;
    logic [WIDTH-1:0] sb_r, sb_s;
    logic [WIDTH-1:0] res_r, res_s;
    logic [WIDTH-1:0] res_shift_s;
    logic             bor_r, bor_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [WIDTH-1:0] diff_r, diff_s;
    logic             borrow_r, borrow_s;
    logic             done_r, done_s;
    logic             busy_r, busy_s;
    logic             d_bit_s;
    logic             bor_bit_s;

    // Current bit of the serial cell.
    always_comb begin
        d_bit_s   = fs_diff(sa_r[0], sb_r[0], bor_r);
        bor_bit_s = fs_borrow(sa_r[0], sb_r[0], bor_r);
    end

    // Result register shifted right with the new difference bit entering at
    // the MSB; after WIDTH shifts bit 0 of the answer sits at position 0.
    // Written as a loop so WIDTH=1 needs no special case.
    always_comb begin
        res_shift_s = res_r;
        for (int i = 0; i < WIDTH - 1; i++) begin
            res_shift_s[i] = res_r[i+1];
        end
        res_shift_s[WIDTH-1] = d_bit_s;
    end

    // Next-state and datapath next values.
    always_comb begin
        state_s  = state_r;
        sa_s     = sa_r;
        sb_s     = sb_r;
        res_s    = res_r;
        bor_s    = bor_r;
        cnt_s    = cnt_r;
        diff_s   = diff_r;
        borrow_s = borrow_r;
        done_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    sa_s    = a;
                    sb_s    = b;
                    res_s   = '0;
                    bor_s   = 1'b0;
                    cnt_s   = '0;
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                sa_s  = sa_r >> 1'b1;
                sb_s  = sb_r >> 1'b1;
                res_s = res_shift_s;
                bor_s = bor_bit_s;
                cnt_s = cnt_r + CNT_ONE;
                // cnt_r still holds the index of the bit being processed,
                // so this is the edge that consumes the MSB.
                if (cnt_r == CNT_LAST) begin
                    diff_s   = res_shift_s;
                    borrow_s = bor_bit_s;
                    done_s   = 1'b1;
                    state_s  = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        // busy is registered, so derive it from the state being entered.
        busy_s = (state_s != ST_IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            sa_r     <= '0;
            sb_r     <= '0;
            res_r    <= '0;
            bor_r    <= 1'b0;
            cnt_r    <= '0;
            diff_r   <= '0;
            borrow_r <= 1'b0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            sa_r     <= sa_s;
            sb_r     <= sb_s;
            res_r    <= res_s;
            bor_r    <= bor_s;
            cnt_r    <= cnt_s;
            diff_r   <= diff_s;
            borrow_r <= borrow_s;
            done_r   <= done_s;
            busy_r   <= busy_s;
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign diff       = diff_r;
    assign borrow_out = borrow_r;

endmodule
